bcd_mod_counter: RTL
====================

Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter; the generalised successor to the single-digit seconds-units register.
- One instance covers a full clock field: seconds or minutes (00–59), 24-hour hours (00–23), or 12-hour hours (01–12).
- Counts up or down and accepts a validated parallel load.
- Emits same-cycle carry and borrow strobes so instances cascade directly (sec → min → hour) on one clock without extra latency.

Parameters:
- MAX_VAL, 59: highest count value in decimal. Legal range is MIN_VAL+1..99.
- MIN_VAL, 0: lowest count value; also the reset and wrap target for up-count. Legal range is 0..MAX_VAL-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- inc  input  1  count-up request, one step per cycle asserted.
- dec  input  1  count-down request, one step per cycle asserted.
- load  input  1  parallel load request.
- new_tens  input  4  BCD tens digit to load.
- new_units  input  4  BCD units digit to load.
- tens  output  4  current tens digit, BCD, registered.
- units  output  4  current units digit, BCD, registered.
- at_max  output  1  combinational; high when count == MAX_VAL.
- at_min  output  1  combinational; high when count == MIN_VAL.
- carry  output  1  combinational; wrap-up strobe for the next stage's inc.
- borrow  output  1  combinational; wrap-down strobe for the next stage's dec.
- load_err  output  1  registered; one-cycle pulse after a rejected load.

Behaviour:
- Reset
  - reset low, asynchronously: tens/units = BCD of MIN_VAL; load_err = 0.
  - Combinational outputs follow (at_min=1, carry=0, borrow=0).
- Priority per rising edge: load > (inc XOR dec) > hold.
  - inc and dec both high: hold; carry = borrow = 0.
- Load
  - Accepted when both new digits are ≤ 9 AND 10*new_tens+new_units lies in [MIN_VAL, MAX_VAL]. Count takes the new value next edge; load_err = 0.
  - Otherwise: count holds; load_err = 1 for exactly the next cycle.
  - inc/dec are ignored in any load cycle, even a rejected one.
- Up-count (inc only)
  - units < 9 and not at_max: units+1.
  - units == 9 and not at_max: units=0, tens+1.
  - at_max: wrap to MIN_VAL.
  - carry = inc & ~dec & ~load & at_max. It is high during the cycle before the wrap edge, so the next stage increments on the same edge.
- Down-count (dec only)
  - units > 0 and not at_min: units-1.
  - units == 0 and not at_min: units=9, tens-1.
  - at_min: wrap to MAX_VAL.
  - borrow = dec & ~inc & ~load & at_min.
- Count never leaves [MIN_VAL, MAX_VAL] and digits never exceed 9 after reset.
  - Illegal internal state (unreachable) recovers to MIN_VAL on the next inc/dec.
- No internal state beyond tens, units and the load_err flop.
- Latency: one cycle from request to new count; carry, borrow, at_max, at_min have zero latency.
- Elaboration: illegal parameter combinations (MIN_VAL ≥ MAX_VAL or MAX_VAL > 99) stop elaboration with an error.

Test Plan:
- Reset: MAX=59/MIN=0; assert reset mid-count at 37, asynchronously between edges → tens/units = 0/0 immediately, at_min=1, load_err=0.
- Up-count: MAX=59/MIN=0; load 58, then inc for 3 cycles → counts 58→59→00→01.
  - carry high only during the cycle count == 59 with inc=1.
  - Units 9→0 with tens+1 checked at 09→10.
- Down-count: MAX=12/MIN=1; load 02, then dec for 3 cycles → 02→01→12→11.
  - borrow high only during the cycle at 01.
  - Check 10→09 digit borrow separately.
- Load validation: MAX=23/MIN=0.
  - Load 24 → count unchanged, load_err=1 for one cycle.
  - Load digits 0/A (units > 9) → rejected, load_err pulse.
  - Load 23 → accepted, at_max=1.
- Simultaneous requests: inc=dec=1 at 59 → count holds at 59, carry=0, borrow=0.
  - load=1 with inc=1 at 59 and new value 30 → count 30, carry=0.
- Cascade: sec (0–59) carry → min inc, min carry → hour (0–23) inc; preload 23:59:58, inc sec for 2 cycles → 23:59:59, then 00:00:00 on the same edge for all three stages.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter (MIN_VAL..MAX_VAL) with up/down, validated load
// and same-cycle carry/borrow strobes so instances cascade on one clock.
module bcd_mod_counter #(
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_load,
    input  logic [3:0] i_new_tens,
    input  logic [3:0] i_new_units,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_at_max,
    output logic       o_at_min,
    output logic       o_carry,
    output logic       o_borrow,
    output logic       o_load_err
);
    localparam logic [7:0] MIN_V = 8'(MIN_VAL);
    localparam logic [7:0] SPAN  = 8'(MAX_VAL - MIN_VAL);
    localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_VAL % 10);
    localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
    localparam logic [3:0] MIN_U = 4'(MIN_VAL % 10);

    generate
        if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_params
            $error("bcd_mod_counter: illegal MIN_VAL/MAX_VAL combination");
        end
    endgenerate

    logic [3:0] r_tens, r_units;
    logic       r_load_err;
    logic [7:0] w_val, w_new_val;
    logic       w_legal, w_load_ok, w_up, w_down;
    logic [3:0] w_tens_nx, w_units_nx;

    assign w_val     = 8'(r_tens) * 8'd10 + 8'(r_units);
    assign w_new_val = 8'(i_new_tens) * 8'd10 + 8'(i_new_units);
    // Unsigned wrap of (v - MIN) turns the two-sided range test into one compare
    assign w_legal   = r_tens <= 4'd9 && r_units <= 4'd9 && (w_val - MIN_V) <= SPAN;
    assign w_load_ok = i_new_tens <= 4'd9 && i_new_units <= 4'd9 && (w_new_val - MIN_V) <= SPAN;
    assign w_up      = i_inc & ~i_dec & ~i_load;
    assign w_down    = i_dec & ~i_inc & ~i_load;

    assign o_tens     = r_tens;
    assign o_units    = r_units;
    assign o_at_max   = r_tens == MAX_T && r_units == MAX_U;
    assign o_at_min   = r_tens == MIN_T && r_units == MIN_U;
    assign o_carry    = w_up & o_at_max;
    assign o_borrow   = w_down & o_at_min;
    assign o_load_err = r_load_err;

    always_comb begin
        {w_tens_nx, w_units_nx} = {r_tens, r_units};
        if (i_load)
            {w_tens_nx, w_units_nx} = w_load_ok ? {i_new_tens, i_new_units} : {r_tens, r_units};
        else if (w_up)
            {w_tens_nx, w_units_nx} = (!w_legal || o_at_max) ? {MIN_T, MIN_U} :
                                      r_units == 4'd9 ? {r_tens + 4'd1, 4'd0} :
                                      {r_tens, r_units + 4'd1};
        else if (w_down)
            {w_tens_nx, w_units_nx} = !w_legal ? {MIN_T, MIN_U} :
                                      o_at_min ? {MAX_T, MAX_U} :
                                      r_units == 4'd0 ? {r_tens - 4'd1, 4'd9} :
                                      {r_tens, r_units - 4'd1};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tens     <= MIN_T;
            r_units    <= MIN_U;
            r_load_err <= 1'b0;
        end else begin
            r_tens     <= w_tens_nx;
            r_units    <= w_units_nx;
            r_load_err <= i_load & ~w_load_ok;
        end
    end
endmodule
